// File: rtl/dfd_trace_pkg.sv
// Shared types and width helpers for the trace-packet accumulator.
//   dfd_accum_state_e : sequencing FSM state (RUN / FLUSH)
//   *_DFLT            : default geometry (64B line, 32B packet) and derived widths
//   acc_ptr_w()       : width of the line fill pointer, $clog2(A)
//   pkt_cnt_w()       : width of the packet byte count, $clog2(B)+1
package dfd_trace_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } dfd_accum_state_e;

  localparam int unsigned ACC_BYTES_DFLT  = 64;
  localparam int unsigned BANK_BYTES_DFLT = 32;
  localparam int unsigned ACC_PTR_W_DFLT  = $clog2(ACC_BYTES_DFLT);
  localparam int unsigned PKT_CNT_W_DFLT  = $clog2(BANK_BYTES_DFLT) + 1;

  function automatic int unsigned acc_ptr_w(input int unsigned acc_bytes);
    return $clog2(acc_bytes);
  endfunction

  function automatic int unsigned pkt_cnt_w(input int unsigned bank_bytes);
    return $clog2(bank_bytes) + 1;
  endfunction

endpackage

// File: rtl/dfd_trace_accum_ctrl_if.sv
// Bundle of the accumulator's packet, line and flush signals.
//   master : trace-encoder / memory-side driver (drives pkt_*, flush_req, line_ready)
//   slave  : the accumulator controller (drives pkt_ready, line_*, flush_done,
//            write_byte_boundary)
interface dfd_trace_accum_ctrl_if
  import dfd_trace_pkg::*;
#(
  parameter int unsigned ACCUMULATOR_DATA_WIDTH_IN_BYTES = ACC_BYTES_DFLT,
  parameter int unsigned BANK_DATA_WIDTH_IN_BYTES        = BANK_BYTES_DFLT
);
  localparam int unsigned A     = ACCUMULATOR_DATA_WIDTH_IN_BYTES;
  localparam int unsigned B     = BANK_DATA_WIDTH_IN_BYTES;
  localparam int unsigned PTR_W = acc_ptr_w(A);
  localparam int unsigned CNT_W = pkt_cnt_w(B);

  logic             pkt_valid;
  logic             pkt_ready;
  logic [B*8-1:0]   pkt_data;
  logic [CNT_W-1:0] pkt_byte_cnt;
  logic             flush_req;
  logic             flush_done;
  logic             line_valid;
  logic             line_ready;
  logic [A*8-1:0]   line_data;
  logic [A-1:0]     line_byte_en;
  logic             line_partial;
  logic [PTR_W-1:0] write_byte_boundary;

  modport master (
    output pkt_valid, pkt_data, pkt_byte_cnt, flush_req, line_ready,
    input  pkt_ready, flush_done, line_valid, line_data, line_byte_en,
           line_partial, write_byte_boundary
  );

  modport slave (
    input  pkt_valid, pkt_data, pkt_byte_cnt, flush_req, line_ready,
    output pkt_ready, flush_done, line_valid, line_data, line_byte_en,
           line_partial, write_byte_boundary
  );

endinterface

// File: rtl/dfd_cross_connect.sv
// Byte aligner: places packet byte i at line position (i_boundary + i) mod A.
//   i_data/i_be     : packet bytes and byte enables (B bytes)
//   i_boundary      : current line fill pointer
//   o_data/o_be     : aligned bytes/enables across the full line (A bytes);
//                     bytes running past the line end wrap to the low positions
module dfd_cross_connect
  import dfd_trace_pkg::*;
#(
  parameter int unsigned ACCUMULATOR_DATA_WIDTH_IN_BYTES = ACC_BYTES_DFLT,
  parameter int unsigned BANK_DATA_WIDTH_IN_BYTES        = BANK_BYTES_DFLT
) (
  input  logic [BANK_DATA_WIDTH_IN_BYTES*8-1:0]        i_data,
  input  logic [BANK_DATA_WIDTH_IN_BYTES-1:0]          i_be,
  input  logic [acc_ptr_w(ACCUMULATOR_DATA_WIDTH_IN_BYTES)-1:0] i_boundary,
  output logic [ACCUMULATOR_DATA_WIDTH_IN_BYTES*8-1:0] o_data,
  output logic [ACCUMULATOR_DATA_WIDTH_IN_BYTES-1:0]   o_be
);
  localparam int unsigned B     = BANK_DATA_WIDTH_IN_BYTES;
  localparam int unsigned PTR_W = acc_ptr_w(ACCUMULATOR_DATA_WIDTH_IN_BYTES);

  logic [PTR_W-1:0] w_pos;

  always_comb begin
    o_data = '0;
    o_be   = '0;
    w_pos  = '0;
    for (int unsigned i = 0; i < B; i++) begin
      // PTR_W-bit add gives the modulo-A wrap for free
      w_pos = i_boundary + PTR_W'(i);
      o_data[32'(w_pos)*8 +: 8] = i_data[i*8 +: 8];
      o_be[w_pos]               = i_be[i];
    end
  end

endmodule

// File: rtl/dfd_trace_accum_ctrl.sv
// Trace-packet accumulator controller.
//   clk, reset_n : single clock, asynchronous active-low reset
//   trc (slave)  : pkt_* packet input, line_* output line (valid/ready),
//                  flush_req/flush_done flush handshake, write_byte_boundary
//                  fill pointer
// Packets are aligned at the fill pointer and merged into the line under
// construction; full lines (including wrap-around splits) and flushed partial
// lines are held in the output register until the sink takes them.
module dfd_trace_accum_ctrl
  import dfd_trace_pkg::*;
#(
  parameter int unsigned ACCUMULATOR_DATA_WIDTH_IN_BYTES = ACC_BYTES_DFLT,
  parameter int unsigned BANK_DATA_WIDTH_IN_BYTES        = BANK_BYTES_DFLT
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dfd_trace_accum_ctrl_if.slave trc
);
  localparam int unsigned A     = ACCUMULATOR_DATA_WIDTH_IN_BYTES;
  localparam int unsigned B     = BANK_DATA_WIDTH_IN_BYTES;
  localparam int unsigned PTR_W = acc_ptr_w(A);
  localparam int unsigned CNT_W = pkt_cnt_w(B);
  localparam int unsigned SUM_W = PTR_W + 1;

  dfd_accum_state_e r_state, w_state_nxt;

  logic [A*8-1:0]   r_acc_data;
  logic [A-1:0]     r_acc_be;
  logic [PTR_W-1:0] r_b;
  logic             r_line_valid;
  logic             r_line_partial;
  logic [A*8-1:0]   r_line_data;
  logic [A-1:0]     r_line_be;

  logic [CNT_W-1:0] w_n;
  logic [B-1:0]     w_pkt_be;
  logic [A*8-1:0]   w_x;
  logic [A-1:0]     w_xe;
  logic [A-1:0]     w_lo_mask, w_hi_xe, w_lo_xe;
  logic [A*8-1:0]   w_merge_data, w_lo_data;
  logic [SUM_W-1:0] w_sum;
  logic             w_out_free, w_pkt_ready, w_accept;
  logic             w_flush_done, w_flush_load, w_line_load;

  // Oversized counts are clamped to a full bank
  always_comb begin
    w_n      = (trc.pkt_byte_cnt > CNT_W'(B)) ? CNT_W'(B) : trc.pkt_byte_cnt;
    w_pkt_be = '0;
    for (int unsigned i = 0; i < B; i++) w_pkt_be[i] = (32'(w_n) > i);
  end

  dfd_cross_connect #(
    .ACCUMULATOR_DATA_WIDTH_IN_BYTES(A),
    .BANK_DATA_WIDTH_IN_BYTES       (B)
  ) u_xconn (
    .i_data    (trc.pkt_data),
    .i_be      (w_pkt_be),
    .i_boundary(r_b),
    .o_data    (w_x),
    .o_be      (w_xe)
  );

  // Bytes at positions >= b complete the current line; bytes that wrapped to
  // positions < b start the next one. For no-wrap and exact-fill the low part
  // is empty, so one merge path serves all three accept cases.
  always_comb begin
    w_lo_mask = '0;
    for (int unsigned j = 0; j < A; j++) w_lo_mask[j] = (32'(r_b) > j);
    w_hi_xe      = w_xe & ~w_lo_mask;
    w_lo_xe      = w_xe & w_lo_mask;
    w_merge_data = r_acc_data;
    w_lo_data    = '0;
    for (int unsigned j = 0; j < A; j++) begin
      if (w_hi_xe[j]) w_merge_data[j*8 +: 8] = w_x[j*8 +: 8];
      if (w_lo_xe[j]) w_lo_data[j*8 +: 8]    = w_x[j*8 +: 8];
    end
  end

  assign w_sum = SUM_W'(r_b) + SUM_W'(w_n);

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= RUN;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (trc.flush_req) w_state_nxt = FLUSH;
      FLUSH:   if (w_flush_done)  w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // FSM: outputs
  always_comb begin
    w_out_free   = ~r_line_valid | trc.line_ready;
    w_pkt_ready  = reset_n & (r_state == RUN) & ~trc.flush_req & w_out_free;
    w_flush_done = (r_state == FLUSH) & ((r_b == '0) | w_out_free);
    w_flush_load = (r_state == FLUSH) & (r_b != '0) & w_out_free;
  end

  assign w_accept    = trc.pkt_valid & w_pkt_ready;
  assign w_line_load = w_accept & (w_sum >= SUM_W'(A));

  // Output line register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_line_valid   <= 1'b0;
      r_line_partial <= 1'b0;
      r_line_data    <= '0;
      r_line_be      <= '0;
    end else if (w_line_load) begin
      r_line_valid   <= 1'b1;
      r_line_partial <= 1'b0;
      r_line_data    <= w_merge_data;
      r_line_be      <= r_acc_be | w_hi_xe;
    end else if (w_flush_load) begin
      r_line_valid   <= 1'b1;
      r_line_partial <= 1'b1;
      r_line_data    <= r_acc_data;
      r_line_be      <= r_acc_be;
    end else if (r_line_valid & trc.line_ready) begin
      r_line_valid   <= 1'b0;
      r_line_partial <= 1'b0;
      r_line_data    <= '0;
      r_line_be      <= '0;
    end
  end

  // Line under construction and fill pointer
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc_data <= '0;
      r_acc_be   <= '0;
      r_b        <= '0;
    end else if (w_accept) begin
      r_b <= w_sum[PTR_W-1:0];
      if (w_line_load) begin
        r_acc_data <= w_lo_data;
        r_acc_be   <= w_lo_xe;
      end else begin
        r_acc_data <= w_merge_data;
        r_acc_be   <= r_acc_be | w_hi_xe;
      end
    end else if (w_flush_load) begin
      r_acc_data <= '0;
      r_acc_be   <= '0;
      r_b        <= '0;
    end
  end

  assign trc.pkt_ready           = w_pkt_ready;
  assign trc.flush_done          = w_flush_done;
  assign trc.line_valid          = r_line_valid;
  assign trc.line_data           = r_line_data;
  assign trc.line_byte_en        = r_line_be;
  assign trc.line_partial        = r_line_partial;
  assign trc.write_byte_boundary = r_b;

  a_pkt_cnt_range: assert property (@(posedge clk) disable iff (!reset_n)
    trc.pkt_valid |-> (trc.pkt_byte_cnt <= CNT_W'(B)));

endmodule

// File: doc/dfd_trace_accum_ctrl.md
# dfd_trace_accum_ctrl

Sequencing controller for the trace-packet accumulator. It accepts variable-length trace packets of up to one bank width, aligns each one with an internal `dfd_cross_connect` instance, and merges the result into a line register. Complete lines go out on a valid/ready interface, including lines split across the accumulator wrap-around. It also owns the write-byte-boundary pointer and the flush sequence, and sits between the trace encoder and the trace memory write path.

## Interface
- `ACCUMULATOR_DATA_WIDTH_IN_BYTES`, default 64: line width `A`; power of 2.
- `BANK_DATA_WIDTH_IN_BYTES`, default 32: packet width `B`; `B <= A`.
- `clk` input, 1: single clock.
- `reset_n` input, 1: asynchronous, active-low reset.
- `pkt_valid` input, 1: packet offered.
- `pkt_ready` output, 1: packet accepted when `pkt_valid & pkt_ready`.
- `pkt_data` input, `B*8`: packet bytes, LSB-first, contiguous from byte 0.
- `pkt_byte_cnt` input, `$clog2(B)+1`: valid bytes, 0..`B`.
- `flush_req` input, 1: level request to emit the partial line.
- `flush_done` output, 1: one-cycle pulse when a flush completes.
- `line_valid` output, 1: output line held.
- `line_ready` input, 1: sink accepts the line.
- `line_data` output, `A*8`: line bytes.
- `line_byte_en` output, `A`: valid bytes of the line.
- `line_partial` output, 1: line was produced by a flush.
- `write_byte_boundary` output, `$clog2(A)`: current fill pointer `b`.

## Operation
- State: `acc_data`/`acc_be` (line under construction), `b`, output register (`line_*`), FSM {`RUN`, `FLUSH`}.
- Packet byte enables are `(1<<n)-1`, where `n` = `pkt_byte_cnt`.
- `n > B` is clamped to `B`; an assertion flags it.
- `n == 0` is accepted as a no-op.
- The cross-connect is fed `pkt_data`, the byte enables and `b`; it returns aligned data/enables `X`/`XE`.
- Accept, no wrap (`b+n < A`): merge `XE` bytes into `acc`; `b <= b+n`.
- Accept, exact fill (`b+n == A`): output register <= `acc` merged with `X`, `line_partial=0`; `acc` cleared; `b <= 0`.
- Accept, wrap (`b+n > A`):
  - Output register <= `acc` merged with the `X` bytes at positions `>= b`.
  - `acc` <= only the `X` bytes at positions `< b`.
  - `b <= b+n-A` (modulo arithmetic on the `$clog2(A)` width).
- `pkt_ready = (state==RUN) & ~flush_req & (~line_valid | line_ready)`.
- `pkt_ready` is low while `reset_n` is low.
- Flush, in `RUN` with `flush_req` high: go to `FLUSH`; no packet is accepted that cycle.
- In `FLUSH`, empty accumulator (`b==0`): pulse `flush_done`, return to `RUN`; no line is emitted.
- In `FLUSH`, non-empty: wait until `~line_valid | line_ready`. Then load output register <= `acc`, `line_byte_en=acc_be`, `line_partial=1`; clear `acc`; `b <= 0`; pulse `flush_done`; return to `RUN`.
- `flush_req` still high after `flush_done` starts another flush; it completes immediately as empty.
- Output register, on `line_valid & line_ready`: cleared, unless reloaded the same cycle.
- While `line_valid & ~line_ready`, `line_*` stay stable.

## Timing
- Reset values: `line_valid`, `line_data`, `line_byte_en`, `line_partial`, `flush_done`, `write_byte_boundary` all 0; FSM in `RUN`.
- Latency: `line_valid` rises 1 cycle after the completing packet is accepted.
- Throughput: 1 packet/cycle while the sink keeps `line_ready` high.
- `pkt_ready` depends combinationally on `line_ready`; there is no skid buffer.
- Flush latency: `flush_done` comes 1 cycle after entering `FLUSH` when not back-pressured.
- Reset asserted mid-line or mid-flush: all state discarded immediately; no partial line is emitted.

## Structure
- Package `dfd_trace_pkg` holds:
  - FSM state enum `dfd_accum_state_e` {`RUN`, `FLUSH`}.
  - Width helper localparams for `$clog2(A)` and `$clog2(B)+1`.
- Sub-module: one `dfd_cross_connect` instance, with `write_byte_boundary` driven from `b`.
- Wrap split mask = `(1<<b)-1` applied to `XE`, generated locally.

## Test plan
- 32B packet then 32B packet from `b=0`, `line_ready=1`:
  - After the first, `b=32` and no line.
  - After the second, the next cycle has `line_valid=1`, `line_byte_en` all ones, bytes 0..31 = packet 1, bytes 32..63 = packet 2, `b=0`.
- Packets of 20B, 32B, 32B:
  - After the second, `b=52`.
  - The third emits a line with bytes 52..63 = packet 3 bytes 0..11.
  - Afterwards `acc` bytes 0..19 = packet 3 bytes 12..31 and `b=20`.
- Line pending with `line_ready=0`:
  - `pkt_ready=0` and `line_*` stable for 10 cycles.
  - Raising `line_ready` gives a handshake in the same cycle and `pkt_ready=1`.
- Flush with `b=20`:
  - Line with `line_byte_en=0x0000_0000_000F_FFFF`, `line_partial=1`.
  - `flush_done` pulses once; `b=0`.
- Flush with `b=0`: `flush_done` 1 cycle after `flush_req`; no `line_valid`.
- Async reset asserted with `b=40` and `line_valid=1`: `line_valid=0` and `b=0` immediately; the next 32B packet lands at byte 0.
